filter_loader_5x5: RTL and testbench

FILTER_LOADER_5X5 -- requirements
Module: filter_loader_5x5

---
 rtl/filter_loader_5x5.sv | 240 ++++++++++++++++++++++++
 tb/tb_filter_loader_5x5.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_loader_5x5.sv
// filter_loader_5x5: streams 16-bit words into 5x5 filters (and optionally a
// 120-word bias vector) and hands each one to a filter buffer via a
// buf_read / buf_finish handshake.
// Optional feature: define ACK_TIMEOUT_EN to abort a job after 256 cycles
// without the awaited buf_finish level while waiting for a filter acknowledge.
// All outputs are registered. buf_read is registered from the next state, so
// the STROBE state acts as a one-cycle setup slot: the filter words settle one
// cycle before buf_read rises.
module filter_loader_5x5 (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [10:0]            num_filters,
  input  logic                   load_bias,
  input  logic [15:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   buf_read,
  input  logic                   buf_finish,
  output logic                   buf_bias_or_filter,
  output logic [15:0]            buf_index,
  output logic [0:4][0:4][15:0]  buf_filter,
  output logic [0:119][15:0]     buf_bias,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [3:0] {
    IDLE, FILL, STROBE, WAIT_ACK, RELEASE, BFILL, BSTROBE, BHOLD, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [10:0]         num_q, num_d;
  logic                bias_en_q, bias_en_d;
  logic [15:0]         idx_q, idx_d;
  logic [2:0]          row_q, row_d;
  logic [2:0]          col_q, col_d;
  logic [6:0]          bcnt_q, bcnt_d;
  logic                bstr_q, bstr_d;
  logic                err_q, err_d;
  logic                fil_we, bias_we, accept;
  logic                in_ready_q, buf_read_q, bof_q, busy_q, done_q;
  logic [0:4][0:4][15:0] filt_q;
  logic [0:119][15:0]    bias_q;
`ifdef ACK_TIMEOUT_EN
  logic [7:0]          tmo_q, tmo_d;
`endif

  assign accept = in_ready_q & in_valid;

  // Next-state, counter and write-enable logic for the load sequence.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    bias_en_d = bias_en_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    bcnt_d    = bcnt_q;
    bstr_d    = bstr_q;
    err_d     = err_q;
    fil_we    = 1'b0;
    bias_we   = 1'b0;
`ifdef ACK_TIMEOUT_EN
    tmo_d     = 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((num_filters == 11'd0) || (num_filters > 11'd1920)) begin
            err_d = 1'b1;
          end else begin
            num_d     = num_filters;
            bias_en_d = load_bias;
            idx_d     = 16'd0;
            row_d     = 3'd0;
            col_d     = 3'd0;
            bcnt_d    = 7'd0;
            state_d   = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (accept) begin
          fil_we = 1'b1;
          if (col_q == 3'd4) begin
            col_d = 3'd0;
            if (row_q == 3'd4) begin
              row_d   = 3'd0;
              state_d = STROBE;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          state_d = FILL;
        end
      end
      STROBE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (buf_finish) begin
          state_d = RELEASE;
        end
`ifdef ACK_TIMEOUT_EN
        else if (tmo_q == 8'd255) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`else
        else begin
          state_d = WAIT_ACK;
        end
`endif
      end
      RELEASE: begin
        if (!buf_finish) begin
          if (idx_q == ({5'd0, num_q} - 16'd1)) begin
            state_d = bias_en_q ? BFILL : DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = FILL;
          end
        end
`ifdef ACK_TIMEOUT_EN
        else if (tmo_q == 8'd255) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`else
        else begin
          state_d = RELEASE;
        end
`endif
      end
      BFILL: begin
        if (accept) begin
          bias_we = 1'b1;
          if (bcnt_q == 7'd119) begin
            bcnt_d  = 7'd0;
            bstr_d  = 1'b0;
            state_d = BSTROBE;
          end else begin
            bcnt_d = bcnt_q + 7'd1;
          end
        end else begin
          state_d = BFILL;
        end
      end
      BSTROBE: begin
        if (bstr_q) begin
          bstr_d  = 1'b0;
          state_d = BHOLD;
        end else begin
          bstr_d = 1'b1;
        end
      end
      BHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, control registers and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= 11'd0;
      bias_en_q  <= 1'b0;
      idx_q      <= 16'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      bcnt_q     <= 7'd0;
      bstr_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      buf_read_q <= 1'b0;
      bof_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      bias_en_q  <= bias_en_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      bcnt_q     <= bcnt_d;
      bstr_q     <= bstr_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == FILL) || (state_d == BFILL);
      buf_read_q <= (state_d == WAIT_ACK) || (state_d == BSTROBE);
      bof_q      <= !((state_d == BSTROBE) || (state_d == BHOLD));
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
`ifdef ACK_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Filter and bias word storage, written as words are accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      bias_q <= '0;
    end else begin
      if (fil_we) begin
        filt_q[row_q][col_q] <= in_data;
      end
      if (bias_we) begin
        bias_q[bcnt_q] <= in_data;
      end
    end
  end

  assign in_ready           = in_ready_q;
  assign buf_read           = buf_read_q;
  assign buf_bias_or_filter = bof_q;
  assign buf_index          = idx_q;
  assign buf_filter         = filt_q;
  assign buf_bias           = bias_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = err_q;

endmodule

// File: tb/tb_filter_loader_5x5.sv
// Testbench for filter_loader_5x5: directed jobs, a stream-level model that
// records every accepted word and checks each buffer write against them.
module tb_filter_loader_5x5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [10:0]           num_filters;
  logic                  load_bias;
  logic [15:0]           in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  buf_read;
  logic                  buf_finish;
  logic                  buf_bias_or_filter;
  logic [15:0]           buf_index;
  logic [0:4][0:4][15:0] buf_filter;
  logic [0:119][15:0]    buf_bias;
  logic                  busy;
  logic                  done;
  logic                  error;

  int errors = 0;
  int checks = 0;

  // model state
  logic [15:0] xq[$];
  int  m_nf = 0;
  int  m_fidx = 0;
  int  read_pulses = 0;
  int  done_cnt = 0;
  int  rd_width = 0;
  int  last_rd_width = 0;
  logic prev_read = 1'b0;
  logic [0:4][0:4][15:0] prev_filt = '0;
  logic resp_en = 1'b1;
  logic abort_feed = 1'b0;

  filter_loader_5x5 dut (
    .clk(clk), .rst(rst), .start(start), .num_filters(num_filters),
    .load_bias(load_bias), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .buf_read(buf_read), .buf_finish(buf_finish),
    .buf_bias_or_filter(buf_bias_or_filter), .buf_index(buf_index),
    .buf_filter(buf_filter), .buf_bias(buf_bias), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Stream model and compare process, sampled on the falling edge.
  always @(negedge clk) begin
    logic [0:4][0:4][15:0] ef;
    int nbad;
    logic [15:0] w;
    if (rst) begin
      xq.delete();
      prev_read = 1'b0;
      rd_width = 0;
    end else begin
      if (start && !busy) begin
        m_nf = int'(num_filters);
        m_fidx = 0;
      end
      if (buf_read && !prev_read) begin
        read_pulses++;
        if (m_fidx < m_nf) begin
          chk("wr_is_filter", buf_bias_or_filter, 1);
          chk("wr_index", buf_index, m_fidx);
          chk("filter_setup_stable", (buf_filter == prev_filt), 1);
          chk("filter_word_count", xq.size(), 25);
          nbad = 0;
          for (int k = 0; k < 25; k++) begin
            w = (xq.size() > 0) ? xq.pop_front() : 16'hxxxx;
            ef[k / 5][k % 5] = w;
            if (buf_filter[k / 5][k % 5] !== w) nbad++;
          end
          chk("filter_words_bad", nbad, 0);
          m_fidx++;
        end else begin
          chk("wr_is_bias", buf_bias_or_filter, 0);
          chk("bias_word_count", xq.size(), 120);
          nbad = 0;
          for (int k = 0; k < 120; k++) begin
            w = (xq.size() > 0) ? xq.pop_front() : 16'hxxxx;
            if (buf_bias[k] !== w) nbad++;
          end
          chk("bias_words_bad", nbad, 0);
        end
      end
      if (buf_read) rd_width++;
      else if (prev_read) begin
        last_rd_width = rd_width;
        rd_width = 0;
      end
      if (in_valid && in_ready) xq.push_back(in_data);
      if (done) done_cnt++;
      if (!busy) chk("idle_quiet", {30'd0, in_ready, buf_read}, 0);
      prev_read = buf_read;
      prev_filt = buf_filter;
    end
  end

  // Buffer responder: acknowledges a filter write one cycle after buf_read rises.
  initial begin
    logic seen;
    seen = 1'b0;
    buf_finish = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && buf_read && buf_bias_or_filter) begin
        if (seen) buf_finish = 1'b1;
        seen = 1'b1;
      end else begin
        seen = 1'b0;
        if (!buf_read) buf_finish = 1'b0;
      end
    end
  end

  task automatic start_job(input int n, input logic lb);
    num_filters = n[10:0];
    load_bias = lb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers filter words base.. then bias words bbase.. until all are accepted.
  task automatic feed(input int n, input logic lb, input int base, input int bbase,
                      input logic gappy, input logic poke);
    int i = 0;
    int guard = 0;
    int total = 25 * n + (lb ? 120 : 0);
    logic tog = 1'b1;
    logic hs;
    while (i < total && guard < 20000 && !abort_feed) begin
      in_data = (i < 25 * n) ? 16'(base + i) : 16'(bbase + i - 25 * n);
      in_valid = gappy ? tog : 1'b1;
      if (poke && i == 5) begin
        start = 1'b1;
        num_filters = 11'd5;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) i++;
      tog = ~tog;
      guard++;
    end
    in_valid = 1'b0;
    if (!abort_feed) chk("feed_complete", i, total);
  endtask

  task automatic wait_done(input int d0);
    int c = 0;
    while (done_cnt == d0 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", (done_cnt != d0), 1);
  endtask

  initial begin
    int p0, d0, c;
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int p0, d0, c;
    rst = 1'b1; start = 1'b0; num_filters = 11'd0; load_bias = 1'b0;
    in_data = 16'd0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_buf_read", buf_read, 0);
    chk("rst_bof", buf_bias_or_filter, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_index", buf_index, 0);
    chk("rst_filter_zero", (buf_filter == '0), 1);
    chk("rst_bias_zero", (buf_bias == '0), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // one filter, words 1..25, with an ignored start mid-fill
    p0 = read_pulses; d0 = done_cnt;
    start_job(1, 1'b0);
    chk("busy_after_start", busy, 1);
    feed(1, 1'b0, 1, 0, 1'b0, 1'b1);
    wait_done(d0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_f44", buf_filter[4][4], 25);
    chk("t1_f00", buf_filter[0][0], 1);
    chk("t1_f23", buf_filter[2][3], 14);
    chk("t1_index", buf_index, 0);
    chk("t1_pulses", read_pulses - p0, 1);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_read_width", last_rd_width, 2);
    chk("t1_busy", busy, 0);
    chk("t1_error", error, 0);

    // three filters with in_valid toggling
    p0 = read_pulses; d0 = done_cnt;
    start_job(3, 1'b0);
    feed(3, 1'b0, 1, 0, 1'b1, 1'b0);
    wait_done(d0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_pulses", read_pulses - p0, 3);
    chk("t2_index", buf_index, 2);
    chk("t2_f00", buf_filter[0][0], 51);
    chk("t2_f44", buf_filter[4][4], 75);

    // one filter plus bias 1000..1119
    p0 = read_pulses; d0 = done_cnt;
    start_job(1, 1'b1);
    feed(1, 1'b1, 300, 1000, 1'b0, 1'b0);
    wait_done(d0);
    #1;
    chk("t3_bof_restored", buf_bias_or_filter, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_pulses", read_pulses - p0, 2);
    chk("t3_bias_width", last_rd_width, 2);
    chk("t3_b0", buf_bias[0], 1000);
    chk("t3_b119", buf_bias[119], 1119);
    chk("t3_f44", buf_filter[4][4], 324);
    chk("t3_error", error, 0);

    // missing acknowledge
    d0 = done_cnt;
    resp_en = 1'b0;
    start_job(1, 1'b0);
    feed(1, 1'b0, 200, 0, 1'b0, 1'b0);
`ifdef ACK_TIMEOUT_EN
    wait_done(d0);
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_error", error, 1);
    chk("tmo_read_width", last_rd_width, 256);
    chk("tmo_buf_read", buf_read, 0);
    chk("tmo_busy", busy, 0);
    resp_en = 1'b1;
`else
    c = 0;
    while (!buf_read && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (300) @(posedge clk);
    #1;
    chk("noack_buf_read_held", buf_read, 1);
    chk("noack_busy", busy, 1);
    chk("noack_error", error, 0);
    resp_en = 1'b1;
    wait_done(d0);
    chk("noack_error_after", error, 0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // reset while the second filter waits for its acknowledge
    resp_en = 1'b0;
    abort_feed = 1'b0;
    start_job(3, 1'b0);
    fork
      feed(3, 1'b0, 500, 0, 1'b0, 1'b0);
      begin
        int cw = 0;
        @(negedge clk);
        while (!(buf_read && buf_index == 16'd1) && cw < 3000) begin
          resp_en = !(buf_index == 16'd1);
          @(negedge clk);
          cw++;
        end
        chk("t5_reached_filter2", (cw < 3000), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_buf_read", buf_read, 0);
        chk("t5_busy", busy, 0);
        chk("t5_index", buf_index, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_filter_zero", (buf_filter == '0), 1);
        abort_feed = 1'b1;
      end
    join
    resp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    abort_feed = 1'b0;
    p0 = read_pulses;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_read_after_rst", read_pulses - p0, 0);
    chk("t5_idle", busy, 0);

    // illegal filter counts
    p0 = read_pulses;
    start_job(1921, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_err_1921", error, 1);
    chk("t4_busy_1921", busy, 0);
    rst = 1'b1;
    #2;
    chk("t4_err_cleared", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_job(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_0", error, 1);
    chk("t4_busy_0", busy, 0);
    chk("t4_no_read", read_pulses - p0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
